sb_rx_wrapper: RTL and testbench
================================

Name: sb_rx_wrapper

Overview:
- UCIe sideband receive wrapper, sitting between the sideband deserializer and the link-training / RDI state machines.
- Consumes 64-bit deserialized words, detects the SBINIT clock pattern, and checks packet parity.
- Decodes message-without-data and message-with-data packets into registered message fields and single-cycle event pulses.

Parameters:
None (widths fixed by the UCIe sideband format).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active-high (asserted when 1, despite the name)
i_de_ser_done  in  1  one-cycle strobe: i_deser_data holds a valid word
i_deser_data  in  64  deserialized word (header or data payload)
i_state  in  3  link state: 0=RESET, 1=SBINIT, other=operational
o_rx_sb_start_pattern  out  1  pulse: first SBINIT pattern word seen
o_rx_sb_pattern_samp_done  out  1  level: two consecutive pattern words seen
o_rdi_msg  out  1  pulse with o_msg_valid when the message is RDI
o_msg_valid  out  1  pulse: decoded message fields are valid
o_parity_error  out  1  pulse: cp or dp mismatch, message dropped
o_rx_rsp_delivered  out  1  pulse: valid response message received
o_adapter_enable  out  1  level: adapter enabled by RDI Active response
o_tx_point_sweep_test_en  out  1  pulse: point-sweep test request received
o_tx_point_sweep_test  out  2  point-sweep test type
o_msg_no  out  4  message subcode[3:0]
o_msg_info  out  3  MsgInfo[2:0]
o_data  out  16  MsgInfo[15:0] (no-data msg) or payload[15:0] (data msg)
o_rdi_msg_code  out  2  01=RDI request, 10=RDI response
o_rdi_msg_sub_code  out  4  RDI subcode[3:0]
o_rdi_msg_info  out  2  MsgInfo[1:0] of RDI message

Behaviour:
- Reset: all outputs 0, FSM in WAIT_HDR, pattern count 0; takes effect asynchronously.
- Words are consumed only when i_de_ser_done=1. If i_state=0, all words are ignored and the FSM/count are cleared.
- Header fields:
  - opcode [4:0]: 5'b10010 = msg without data, 5'b11011 = msg with data.
  - msgcode [21:14], msgsubcode [39:32], MsgInfo [55:40], dstid [58:56].
  - cp [62], dp [63].
- Control parity: cp must equal XOR of bits [61:0]. Data parity: dp from the header must equal XOR of all 64 payload bits.
- Pattern detection (i_state=1 only):
  - A word equal to 64'hAAAA_AAAA_AAAA_AAAA is a pattern word and is not decoded.
  - First pattern word: o_rx_sb_start_pattern pulses 1 cycle after the strobe.
  - Second consecutive pattern word: o_rx_sb_pattern_samp_done set, held until i_state != 1.
  - A non-pattern word clears the count.
- FSM WAIT_HDR:
  - Valid opcode with no-data and good cp: outputs update and o_msg_valid pulses 1 cycle after the strobe.
  - With-data opcode: header is latched and the FSM goes to WAIT_DATA.
  - Unknown opcode: word silently dropped.
- FSM WAIT_DATA:
  - The next strobe is the payload. Outputs and o_msg_valid follow 1 cycle later; the FSM returns to WAIT_HDR.
  - i_state=0 aborts to WAIT_HDR.
- Parity error:
  - cp bad (no-data), or cp/dp bad (data): o_parity_error pulses at the cycle o_msg_valid would have.
  - No o_msg_valid and no side pulses; field outputs keep their old values.
  - A with-data header with bad cp still consumes its payload word.
- Field outputs are registered and held until the next valid message.
- Classification (evaluated on valid messages):
  - msgcode 8'h01 (req) / 8'h02 (rsp): RDI. o_rdi_msg pulses; rdi code/sub_code/info update.
  - RDI response with subcode 4'h1 sets o_adapter_enable; any other RDI subcode clears it.
  - msgcode[3:0]=4'hA (e.g. 0xAA, 0x9A) is a response: o_rx_rsp_delivered pulses.
  - msgcode 8'hB5: o_tx_point_sweep_test_en pulses; o_tx_point_sweep_test = subcode[1:0].
  - o_msg_no, o_msg_info, o_data update for every valid message.
- All pulses are exactly 1 cycle wide. Back-to-back strobes on consecutive cycles are supported.

Test Plan:
- Reset, i_state=1, word 64'hAAAA_AAAA_AAAA_AAAA -> o_rx_sb_start_pattern pulse 1 cycle later, no o_msg_valid; a second identical word -> o_rx_sb_pattern_samp_done=1.
- Header opcode 10010, msgcode A5, subcode 02, dstid 110, cp=1 -> o_msg_valid pulse, o_msg_no=2, o_data=0, o_parity_error=0, o_rx_rsp_delivered=0.
- Header opcode 11011, msgcode A5, subcode 00, cp=0, dp=0, then payload 11'b10101010101 -> o_msg_valid only after the payload strobe, o_data=16'h0555.
- Header opcode 10010, msgcode AA, subcode 04, MsgInfo FFFF, cp=1 -> o_msg_valid + o_rx_rsp_delivered, o_msg_no=4, o_data=16'hFFFF, o_msg_info=3'b111.
- Same header with cp flipped -> o_parity_error pulse, no o_msg_valid, outputs unchanged.
- RDI rsp msgcode 02, subcode 1, MsgInfo 2 -> o_rdi_msg pulse, o_rdi_msg_code=10, o_rdi_msg_sub_code=1, o_rdi_msg_info=2, o_adapter_enable=1; assert reset mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/sb_rx_wrapper_if.sv
// Sideband receive bus: deserializer/link-state inputs and decoded message outputs.
interface sb_rx_wrapper_if;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned STATE_W = 3;

  logic                i_de_ser_done;
  logic [WORD_W-1:0]   i_deser_data;
  logic [STATE_W-1:0]  i_state;

  logic                o_rx_sb_start_pattern;
  logic                o_rx_sb_pattern_samp_done;
  logic                o_rdi_msg;
  logic                o_msg_valid;
  logic                o_parity_error;
  logic                o_rx_rsp_delivered;
  logic                o_adapter_enable;
  logic                o_tx_point_sweep_test_en;
  logic [1:0]          o_tx_point_sweep_test;
  logic [3:0]          o_msg_no;
  logic [2:0]          o_msg_info;
  logic [15:0]         o_data;
  logic [1:0]          o_rdi_msg_code;
  logic [3:0]          o_rdi_msg_sub_code;
  logic [1:0]          o_rdi_msg_info;

  // Deserializer / link-training side: drives words, observes decoded results
  modport master (
    output i_de_ser_done, i_deser_data, i_state,
    input  o_rx_sb_start_pattern, o_rx_sb_pattern_samp_done, o_rdi_msg, o_msg_valid,
           o_parity_error, o_rx_rsp_delivered, o_adapter_enable, o_tx_point_sweep_test_en,
           o_tx_point_sweep_test, o_msg_no, o_msg_info, o_data, o_rdi_msg_code,
           o_rdi_msg_sub_code, o_rdi_msg_info
  );

  // Receive wrapper side
  modport slave (
    input  i_de_ser_done, i_deser_data, i_state,
    output o_rx_sb_start_pattern, o_rx_sb_pattern_samp_done, o_rdi_msg, o_msg_valid,
           o_parity_error, o_rx_rsp_delivered, o_adapter_enable, o_tx_point_sweep_test_en,
           o_tx_point_sweep_test, o_msg_no, o_msg_info, o_data, o_rdi_msg_code,
           o_rdi_msg_sub_code, o_rdi_msg_info
  );
endinterface

// File: rtl/sb_rx_wrapper.sv
// UCIe sideband receive wrapper: SBINIT pattern detect, parity check and message decode.
module sb_rx_wrapper (
  input  logic            i_clk,
  input  logic            i_rst_n,   // active-high asynchronous reset
  sb_rx_wrapper_if.slave  bus
);

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PATCNT_W = 2;

  localparam logic [4:0]         OP_NODATA  = 5'b10010;
  localparam logic [4:0]         OP_DATA    = 5'b11011;
  localparam logic [WORD_W-1:0]  SB_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [STATE_W-1:0] ST_RESET   = 3'd0;
  localparam logic [STATE_W-1:0] ST_SBINIT  = 3'd1;
  localparam logic [7:0]         MC_RDI_REQ = 8'h01;
  localparam logic [7:0]         MC_RDI_RSP = 8'h02;
  localparam logic [7:0]         MC_SWEEP   = 8'hB5;

  typedef struct packed {
    logic [7:0]  msgcode;
    logic [3:0]  subcode;
    logic [15:0] info;
    logic        dp;
    logic        cp_ok;
  } hdr_t;

  typedef enum logic [0:0] {WAIT_HDR = 1'b0, WAIT_DATA = 1'b1} fsm_e;

  fsm_e                 state_q, state_d;
  hdr_t                 hdr_q, hdr_d;
  hdr_t                 word_hdr;
  hdr_t                 fld;
  logic [WORD_W-1:0]    word;
  logic                 link_reset, in_sbinit, is_pat, take;
  logic                 fire, perr, use_payload;
  logic                 is_rdi, is_rsp, is_sweep;
  logic [PATCNT_W-1:0]  pat_cnt_q;

  logic        start_q, samp_done_q, rdi_msg_q, msg_valid_q, parity_err_q;
  logic        rsp_q, adapter_en_q, sweep_en_q;
  logic [1:0]  sweep_q;
  logic [3:0]  msg_no_q;
  logic [2:0]  msg_info_q;
  logic [15:0] data_q;
  logic [1:0]  rdi_code_q;
  logic [3:0]  rdi_sub_q;
  logic [1:0]  rdi_info_q;

  // Word qualification and header field extraction
  always_comb begin
    word       = bus.i_deser_data;
    link_reset = (bus.i_state == ST_RESET);
    in_sbinit  = (bus.i_state == ST_SBINIT);
    is_pat     = in_sbinit && (word == SB_PATTERN);
    take       = bus.i_de_ser_done && !link_reset && !is_pat;
    word_hdr   = '{msgcode: word[21:14], subcode: word[35:32], info: word[55:40],
                   dp: word[63], cp_ok: (word[62] == (^word[61:0]))};
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q <= WAIT_HDR;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
    end
  end

  // FSM next state: a with-data header waits for exactly one payload word
  always_comb begin
    state_d = state_q;
    if (link_reset) begin
      state_d = WAIT_HDR;
    end else if (take) begin
      case (state_q)
        WAIT_HDR:  if (word[4:0] == OP_DATA) state_d = WAIT_DATA;
        WAIT_DATA: state_d = WAIT_HDR;
        default:   state_d = WAIT_HDR;
      endcase
    end
  end

  // FSM outputs: message completion, parity verdict and field source selection
  always_comb begin
    hdr_d       = hdr_q;
    fld         = word_hdr;
    use_payload = 1'b0;
    fire        = 1'b0;
    perr        = 1'b0;
    if (take) begin
      case (state_q)
        WAIT_HDR: begin
          if (word[4:0] == OP_NODATA) begin
            fire = word_hdr.cp_ok;
            perr = !word_hdr.cp_ok;
          end else if (word[4:0] == OP_DATA) begin
            hdr_d = word_hdr;
          end
        end
        WAIT_DATA: begin
          fld         = hdr_q;
          use_payload = 1'b1;
          fire        = hdr_q.cp_ok && (hdr_q.dp == (^word));
          perr        = !fire;
        end
        default: ;
      endcase
    end
  end

  // Message classification on the selected header fields
  always_comb begin
    is_rdi   = (fld.msgcode == MC_RDI_REQ) || (fld.msgcode == MC_RDI_RSP);
    is_rsp   = (fld.msgcode[3:0] == 4'hA);
    is_sweep = (fld.msgcode == MC_SWEEP);
  end

  // SBINIT pattern counter: two consecutive pattern words complete sampling
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      pat_cnt_q   <= '0;
      start_q     <= 1'b0;
      samp_done_q <= 1'b0;
    end else begin
      start_q <= bus.i_de_ser_done && is_pat && (pat_cnt_q == '0);
      if (!in_sbinit) begin
        pat_cnt_q   <= '0;
        samp_done_q <= 1'b0;
      end else if (bus.i_de_ser_done) begin
        if (is_pat) begin
          if (pat_cnt_q == PATCNT_W'(1)) samp_done_q <= 1'b1;
          if (pat_cnt_q != PATCNT_W'(2)) pat_cnt_q <= pat_cnt_q + PATCNT_W'(1);
        end else begin
          pat_cnt_q <= '0;
        end
      end
    end
  end

  // Decoded fields held until the next good message; event pulses last one cycle
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      rdi_msg_q    <= 1'b0;
      msg_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      rsp_q        <= 1'b0;
      adapter_en_q <= 1'b0;
      sweep_en_q   <= 1'b0;
      sweep_q      <= '0;
      msg_no_q     <= '0;
      msg_info_q   <= '0;
      data_q       <= '0;
      rdi_code_q   <= '0;
      rdi_sub_q    <= '0;
      rdi_info_q   <= '0;
    end else begin
      msg_valid_q  <= fire;
      parity_err_q <= perr;
      rdi_msg_q    <= fire && is_rdi;
      rsp_q        <= fire && is_rsp;
      sweep_en_q   <= fire && is_sweep;
      if (fire) begin
        msg_no_q   <= fld.subcode;
        msg_info_q <= fld.info[2:0];
        data_q     <= use_payload ? word[15:0] : fld.info;
        if (is_rdi) begin
          rdi_code_q <= fld.msgcode[1:0];
          rdi_sub_q  <= fld.subcode;
          rdi_info_q <= fld.info[1:0];
          if (fld.msgcode == MC_RDI_RSP) adapter_en_q <= (fld.subcode == 4'h1);
        end
        if (is_sweep) sweep_q <= fld.subcode[1:0];
      end
    end
  end

  assign bus.o_rx_sb_start_pattern     = start_q;
  assign bus.o_rx_sb_pattern_samp_done = samp_done_q;
  assign bus.o_rdi_msg                 = rdi_msg_q;
  assign bus.o_msg_valid               = msg_valid_q;
  assign bus.o_parity_error            = parity_err_q;
  assign bus.o_rx_rsp_delivered        = rsp_q;
  assign bus.o_adapter_enable          = adapter_en_q;
  assign bus.o_tx_point_sweep_test_en  = sweep_en_q;
  assign bus.o_tx_point_sweep_test     = sweep_q;
  assign bus.o_msg_no                  = msg_no_q;
  assign bus.o_msg_info                = msg_info_q;
  assign bus.o_data                    = data_q;
  assign bus.o_rdi_msg_code            = rdi_code_q;
  assign bus.o_rdi_msg_sub_code        = rdi_sub_q;
  assign bus.o_rdi_msg_info            = rdi_info_q;

endmodule

// File: tb/tb_sb_rx_wrapper.sv
// Self-checking bench for sb_rx_wrapper: directed vector table, corner sequences, random vs model.
module tb_sb_rx_wrapper;

  localparam logic [63:0] PAT   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [4:0]  OP_ND = 5'b10010;
  localparam logic [4:0]  OP_WD = 5'b11011;

  typedef struct packed {
    logic        start;
    logic        samp;
    logic        valid;
    logic        perr;
    logic        rdi;
    logic        rsp;
    logic        aen;
    logic        swen;
    logic [1:0]  sw;
    logic [3:0]  no;
    logic [2:0]  info;
    logic [15:0] data;
    logic [1:0]  rcode;
    logic [3:0]  rsub;
    logic [1:0]  rinfo;
  } out_t;

  typedef struct {
    logic        d;
    logic [63:0] w;
    logic [2:0]  st;
    out_t        exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sb_rx_wrapper_if bus();

  sb_rx_wrapper dut (
    .i_clk   (clk),
    .i_rst_n (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  out_t        m_out;
  logic        m_pending;
  logic [63:0] m_hdr;
  int          m_patcnt;

  function automatic logic odd(input logic [63:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  function automatic logic [63:0] mk(input logic [4:0] op, input logic [7:0] mc, input logic [7:0] sc,
                                     input logic [15:0] info, input logic [2:0] dst, input logic dp,
                                     input logic bad_cp);
    logic [63:0] w;
    w = '0;
    w[4:0]   = op;
    w[21:14] = mc;
    w[39:32] = sc;
    w[55:40] = info;
    w[58:56] = dst;
    w[63]    = dp;
    w[62]    = odd({2'b00, w[61:0]}) ^ bad_cp;
    return w;
  endfunction

  function automatic out_t ov(input logic start, input logic samp, input logic valid, input logic perr,
                              input logic rdi, input logic rsp, input logic aen, input logic swen,
                              input logic [1:0] sw, input logic [3:0] no, input logic [2:0] info,
                              input logic [15:0] data, input logic [1:0] rcode, input logic [3:0] rsub,
                              input logic [1:0] rinfo);
    out_t o;
    o = '{start, samp, valid, perr, rdi, rsp, aen, swen, sw, no, info, data, rcode, rsub, rinfo};
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.start = bus.o_rx_sb_start_pattern;
    o.samp  = bus.o_rx_sb_pattern_samp_done;
    o.valid = bus.o_msg_valid;
    o.perr  = bus.o_parity_error;
    o.rdi   = bus.o_rdi_msg;
    o.rsp   = bus.o_rx_rsp_delivered;
    o.aen   = bus.o_adapter_enable;
    o.swen  = bus.o_tx_point_sweep_test_en;
    o.sw    = bus.o_tx_point_sweep_test;
    o.no    = bus.o_msg_no;
    o.info  = bus.o_msg_info;
    o.data  = bus.o_data;
    o.rcode = bus.o_rdi_msg_code;
    o.rsub  = bus.o_rdi_msg_sub_code;
    o.rinfo = bus.o_rdi_msg_info;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h (start samp valid perr rdi rsp aen swen | sw no info data rcode rsub rinfo)",
               name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out     = '0;
    m_pending = 1'b0;
    m_hdr     = '0;
    m_patcnt  = 0;
  endtask

  // A complete, parity-checked message updates the visible fields
  task automatic deliver(input logic [63:0] h, input logic [63:0] payload, input logic with_data,
                         input logic good);
    logic [7:0] mc;
    if (!good) begin
      m_out.perr = 1'b1;
      return;
    end
    mc          = h[21:14];
    m_out.valid = 1'b1;
    m_out.no    = h[35:32];
    m_out.info  = h[42:40];
    m_out.data  = with_data ? payload[15:0] : h[55:40];
    if (mc == 8'h01 || mc == 8'h02) begin
      m_out.rdi   = 1'b1;
      m_out.rcode = (mc == 8'h01) ? 2'b01 : 2'b10;
      m_out.rsub  = h[35:32];
      m_out.rinfo = h[41:40];
      if (mc == 8'h02) m_out.aen = (h[35:32] == 4'h1);
    end
    if (mc[3:0] == 4'hA) m_out.rsp = 1'b1;
    if (mc == 8'hB5) begin
      m_out.swen = 1'b1;
      m_out.sw   = h[33:32];
    end
  endtask

  task automatic model_apply(input logic d, input logic [63:0] w, input logic [2:0] st);
    m_out.start = 1'b0;
    m_out.valid = 1'b0;
    m_out.perr  = 1'b0;
    m_out.rdi   = 1'b0;
    m_out.rsp   = 1'b0;
    m_out.swen  = 1'b0;
    if (st != 3'd1) begin
      m_patcnt   = 0;
      m_out.samp = 1'b0;
    end
    if (st == 3'd0) begin
      m_pending = 1'b0;
    end else if (d) begin
      if (st == 3'd1 && w == PAT) begin
        if (m_patcnt == 0) m_out.start = 1'b1;
        else m_out.samp = 1'b1;
        m_patcnt++;
      end else begin
        m_patcnt = 0;
        if (m_pending) begin
          m_pending = 1'b0;
          deliver(m_hdr, w, 1'b1, (m_hdr[62] == odd({2'b00, m_hdr[61:0]})) && (m_hdr[63] == odd(w)));
        end else if (w[4:0] == OP_ND) begin
          deliver(w, 64'd0, 1'b0, w[62] == odd({2'b00, w[61:0]}));
        end else if (w[4:0] == OP_WD) begin
          m_pending = 1'b1;
          m_hdr     = w;
        end
      end
    end
  endtask

  // Apply one cycle of input starting at a falling edge; returns at the next falling edge
  task automatic step(input logic d, input logic [63:0] w, input logic [2:0] st);
    bus.i_de_ser_done = d;
    bus.i_deser_data  = w;
    bus.i_state       = st;
    model_apply(d, w, st);
    @(negedge clk);
  endtask

  vec_t        tbl[20];
  logic [63:0] h1, hd, h3, h3b, hr, hs, hd2, hd3;

  initial begin
    h1  = mk(OP_ND, 8'hA5, 8'h02, 16'h0000, 3'b110, 1'b0, 1'b0);
    hd  = mk(OP_WD, 8'hA5, 8'h00, 16'h0000, 3'b000, 1'b0, 1'b0);
    h3  = mk(OP_ND, 8'hAA, 8'h04, 16'hFFFF, 3'b000, 1'b0, 1'b0);
    h3b = h3 ^ 64'h4000_0000_0000_0000;
    hr  = mk(OP_ND, 8'h02, 8'h01, 16'h0002, 3'b000, 1'b0, 1'b0);
    hs  = mk(OP_ND, 8'hB5, 8'h03, 16'h0000, 3'b000, 1'b0, 1'b0);
    hd2 = mk(OP_WD, 8'h9A, 8'h06, 16'h0005, 3'b000, 1'b1, 1'b0);
    hd3 = mk(OP_WD, 8'h9A, 8'h06, 16'h0005, 3'b000, 1'b0, 1'b1);

    tbl[0]  = '{1'b0, 64'd0,   3'd1, ov(0,0,0,0,0,0,0,0,0,0,0,16'h0000,0,0,0), "idle_sbinit"};
    tbl[1]  = '{1'b1, PAT,     3'd1, ov(1,0,0,0,0,0,0,0,0,0,0,16'h0000,0,0,0), "pattern_first"};
    tbl[2]  = '{1'b1, PAT,     3'd1, ov(0,1,0,0,0,0,0,0,0,0,0,16'h0000,0,0,0), "pattern_second"};
    tbl[3]  = '{1'b0, 64'd0,   3'd1, ov(0,1,0,0,0,0,0,0,0,0,0,16'h0000,0,0,0), "samp_done_held"};
    tbl[4]  = '{1'b0, 64'd0,   3'd2, ov(0,0,0,0,0,0,0,0,0,0,0,16'h0000,0,0,0), "samp_done_clear"};
    tbl[5]  = '{1'b1, h1,      3'd2, ov(0,0,1,0,0,0,0,0,0,2,0,16'h0000,0,0,0), "nodata_A5"};
    tbl[6]  = '{1'b1, hd,      3'd2, ov(0,0,0,0,0,0,0,0,0,2,0,16'h0000,0,0,0), "data_hdr_wait"};
    tbl[7]  = '{1'b1, 64'h555, 3'd2, ov(0,0,1,0,0,0,0,0,0,0,0,16'h0555,0,0,0), "data_payload"};
    tbl[8]  = '{1'b1, h3,      3'd2, ov(0,0,1,0,0,1,0,0,0,4,7,16'hFFFF,0,0,0), "rsp_AA"};
    tbl[9]  = '{1'b1, h3b,     3'd2, ov(0,0,0,1,0,0,0,0,0,4,7,16'hFFFF,0,0,0), "cp_error"};
    tbl[10] = '{1'b1, hr,      3'd2, ov(0,0,1,0,1,0,1,0,0,1,2,16'h0002,2,1,2), "rdi_rsp_active"};
    tbl[11] = '{1'b1, hs,      3'd2, ov(0,0,1,0,0,0,1,1,3,3,0,16'h0000,2,1,2), "point_sweep"};
    tbl[12] = '{1'b1, PAT,     3'd2, ov(0,0,0,0,0,0,1,0,3,3,0,16'h0000,2,1,2), "pattern_operational"};
    tbl[13] = '{1'b1, hd2,     3'd2, ov(0,0,0,0,0,0,1,0,3,3,0,16'h0000,2,1,2), "data_hdr_dp1"};
    tbl[14] = '{1'b1, 64'h3,   3'd2, ov(0,0,0,1,0,0,1,0,3,3,0,16'h0000,2,1,2), "dp_error"};
    tbl[15] = '{1'b1, hd3,     3'd2, ov(0,0,0,0,0,0,1,0,3,3,0,16'h0000,2,1,2), "data_hdr_badcp"};
    tbl[16] = '{1'b1, 64'h0,   3'd2, ov(0,0,0,1,0,0,1,0,3,3,0,16'h0000,2,1,2), "badcp_payload"};
    tbl[17] = '{1'b1, hd2,     3'd2, ov(0,0,0,0,0,0,1,0,3,3,0,16'h0000,2,1,2), "data_hdr_9A"};
    tbl[18] = '{1'b1, 64'h7,   3'd2, ov(0,0,1,0,0,1,1,0,3,6,5,16'h0007,2,1,2), "data_rsp_9A"};
    tbl[19] = '{1'b0, 64'h0,   3'd2, ov(0,0,0,0,0,0,1,0,3,6,5,16'h0007,2,1,2), "fields_held"};

    bus.i_de_ser_done = 1'b0;
    bus.i_deser_data  = '0;
    bus.i_state       = 3'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", '0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].d, tbl[i].w, tbl[i].st);
      check(tbl[i].name, tbl[i].exp);
    end

    // Reset asserted with a header pending: outputs clear immediately, FSM back to header
    step(1'b1, hd, 3'd2);
    check("pending_hdr", m_out);
    bus.i_de_ser_done = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 64'h555, 3'd2);
    check("post_reset_no_payload", m_out);
    step(1'b1, h1, 3'd2);
    check("post_reset_msg", m_out);

    // Link reset aborts a pending payload and ignores words
    step(1'b1, hd, 3'd2);
    step(1'b0, 64'd0, 3'd0);
    check("abort_idle", m_out);
    step(1'b1, h3, 3'd0);
    check("state0_ignored", m_out);
    step(1'b1, h1, 3'd2);
    check("abort_then_msg", m_out);

    // A decoded word in SBINIT breaks the pattern run
    step(1'b1, PAT, 3'd1);
    check("pat_run1", m_out);
    step(1'b1, h3, 3'd1);
    check("pat_break_msg", m_out);
    step(1'b1, PAT, 3'd1);
    check("pat_restart", m_out);
    step(1'b1, PAT, 3'd1);
    check("pat_samp", m_out);

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      logic        d;
      logic [2:0]  st;
      logic [63:0] w;
      logic [7:0]  mc;
      logic [7:0]  sc;
      int          k, r;
      r  = int'($urandom_range(0, 19));
      st = (r == 0) ? 3'd0 : (r < 6) ? 3'd1 : 3'(2 + $urandom_range(0, 5));
      d  = ($urandom_range(0, 9) < 7);
      k  = int'($urandom_range(0, 9));
      case ($urandom_range(0, 6))
        0:       mc = 8'h02;
        1:       mc = 8'hAA;
        2:       mc = 8'h9A;
        3:       mc = 8'hB5;
        4:       mc = 8'hA5;
        5:       mc = 8'h3A;
        default: mc = 8'($urandom);
      endcase
      if (mc == 8'h01) mc = 8'h03;
      sc = (mc == 8'h02) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if (m_pending) begin
        w = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) w[63] = m_hdr[63] ^ odd({1'b0, w[62:0]});
        if (st == 3'd1 && w == PAT) w[0] = 1'b0;
      end else if (k < 2) begin
        w = PAT;
      end else if (k < 6) begin
        w = mk(OP_ND, mc, sc, 16'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      end else if (k < 8) begin
        w = mk(OP_WD, mc, sc, 16'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
      end else begin
        w = {$urandom, $urandom};
      end
      step(d, w, st);
      check("random", m_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
